// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b pipeline types: stall-controller state encoding and counter width.
package lc3b_types;

    localparam int unsigned CTR_W = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IWAIT = 2'd1,
        DWAIT = 2'd2
    } lc3b_stall_state;

endpackage

// File: rtl/stall_counter.sv
// Saturating event counter: increments on inc_i, holds at all-ones, async active-low clear.
module stall_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: step only while below the saturation value.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline advance/freeze/squash controller for the five-stage LC-3b datapath.
// Optional performance counters are built when STALL_CTR_EN is defined.
module pipeline_stall_ctrl
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bubble_enable,
    input  logic        icache_read,
    input  logic        icache_resp,
    input  logic        dcache_read,
    input  logic        dcache_write,
    input  logic        dcache_resp,
    input  logic        branch_taken,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        if_id_nop,
    output logic        id_ex_nop,
    output logic        ex_mem_nop,
    output logic [1:0]  ctrl_state
`ifdef STALL_CTR_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] bubble_count,
    output logic [15:0] flush_count
`endif
);

    lc3b_stall_state state_q;
    lc3b_stall_state state_d;
    logic            bub_mask_q;
    logic            bub_mask_d;
    logic            dmiss;
    logic            imiss;
    logic            bubble_issue;
    logic            flush_issue;

    assign dmiss = (dcache_read | dcache_write) & ~dcache_resp;
    assign imiss = icache_read & ~icache_resp;

    // Priority decode of enables, NOP strobes, next state and bubble mask.
    always_comb begin
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
        if_id_nop    = 1'b0;
        id_ex_nop    = 1'b0;
        ex_mem_nop   = 1'b0;
        state_d      = RUN;
        bub_mask_d   = bub_mask_q;
        bubble_issue = 1'b0;
        flush_issue  = 1'b0;

        if (dmiss) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
            state_d     = DWAIT;
        end else if (imiss) begin
            state_d = IWAIT;
            if (branch_taken) begin
                // Freeze everything so MEM keeps the redirect until the fetch lands.
                load_pc     = 1'b0;
                load_if_id  = 1'b0;
                load_id_ex  = 1'b0;
                load_ex_mem = 1'b0;
                load_mem_wb = 1'b0;
            end else begin
                // Drain downstream; ID/EX advances without a bubble.
                load_pc    = 1'b0;
                if_id_nop  = 1'b1;
                bub_mask_d = 1'b0;
            end
        end else if (branch_taken) begin
            if_id_nop   = 1'b1;
            id_ex_nop   = 1'b1;
            ex_mem_nop  = 1'b1;
            bub_mask_d  = 1'b0;
            flush_issue = 1'b1;
        end else if (bubble_enable && !bub_mask_q) begin
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            id_ex_nop    = 1'b1;
            bub_mask_d   = 1'b1;
            bubble_issue = 1'b1;
        end else begin
            bub_mask_d = 1'b0;
        end

        // Hold the whole pipeline and inject NOPs while in reset.
        if (!rst_n) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
            if_id_nop   = 1'b1;
            id_ex_nop   = 1'b1;
            ex_mem_nop  = 1'b1;
        end
    end

    // State and bubble-mask registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            bub_mask_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bub_mask_q <= bub_mask_d;
        end
    end

    assign ctrl_state = 2'(state_q);

`ifdef STALL_CTR_EN
    stall_counter #(.WIDTH(CTR_W)) u_stall_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (~load_pc),
        .count_o (stall_cycles)
    );

    stall_counter #(.WIDTH(CTR_W)) u_bubble_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (bubble_issue),
        .count_o (bubble_count)
    );

    stall_counter #(.WIDTH(CTR_W)) u_flush_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (flush_issue),
        .count_o (flush_count)
    );
`else
    logic unused_ok;
    assign unused_ok = bubble_issue ^ flush_issue;
`endif

endmodule
